// File: rtl/wb_soc_reg_pkg.sv
// Shared constants for the video-in Wishbone register slave.
package wb_soc_reg_pkg;

    // Word offsets, decoded on ADR_I[3:2]
    localparam logic [1:0] ADDR_OFS = 2'd0;
    localparam logic [1:0] IRQ_OFS  = 2'd1;

    // Bit positions inside the IRQ register
    localparam int IRQ_BIT  = 0;
    localparam int INIT_BIT = 1;

    // Extract the decoded word offset from a byte address
    function automatic logic [1:0] reg_ofs(input logic [31:0] adr);
        return adr[3:2];
    endfunction

endpackage

// File: rtl/wb_soc_reg_slave.sv
// Wishbone register slave for the video-in capture path: frame-buffer start
// address register, sticky initialized flag and a latched capture interrupt.
module wb_soc_reg_slave (
    input  logic        p_clk_100mhz,
    input  logic        p_resetn,
    input  logic        raise_irq,
    output logic        irq,
    output logic [31:0] module_register,
    output logic        initialized,
    input  logic [31:0] p_wb_reg_DAT_I,
    output logic [31:0] p_wb_reg_DAT_O,
    input  logic [31:0] p_wb_reg_ADR_I,
    output logic        p_wb_reg_ACK_O,
    input  logic        p_wb_reg_CYC_I,
    output logic        p_wb_reg_ERR_O,
    input  logic        p_wb_reg_LOCK_I,
    output logic        p_wb_reg_RTY_O,
    input  logic [3:0]  p_wb_reg_SEL_I,
    input  logic        p_wb_reg_STB_I,
    input  logic        p_wb_reg_WE_I
);
    import wb_soc_reg_pkg::*;

    logic [31:0] addr_q, addr_d;
    logic        init_q, init_d;
    logic        irq_q, irq_d;
    logic        raise_irq_q;
    logic [31:0] dat_q, dat_d;
    logic        ack_q, ack_d;

    logic        acc, wr, rd;
    logic [1:0]  ofs;
    logic        irq_set, irq_clr;
    logic [31:0] rdata;

    // LOCK and the undecoded address bits have no function in this block
    logic unused_inputs;
    assign unused_inputs = ^{p_wb_reg_LOCK_I, p_wb_reg_ADR_I[31:4], p_wb_reg_ADR_I[1:0]};

    // Decode, byte-lane write, interrupt edge detect and read mux
    always_comb begin
        // A cycle is accepted only when ACK is low, so a held STB gets one ACK per two cycles
        acc     = p_wb_reg_CYC_I & p_wb_reg_STB_I & ~ack_q;
        wr      = acc & p_wb_reg_WE_I;
        rd      = acc & ~p_wb_reg_WE_I;
        ofs     = reg_ofs(p_wb_reg_ADR_I);
        ack_d   = acc;

        addr_d  = addr_q;
        for (int i = 0; i < 4; i++) begin
            if (wr && (ofs == ADDR_OFS) && p_wb_reg_SEL_I[i]) begin
                addr_d[8*i +: 8] = p_wb_reg_DAT_I[8*i +: 8];
            end
        end
        init_d  = init_q | (wr && (ofs == ADDR_OFS) && (p_wb_reg_SEL_I != 4'd0));

        // A new capture event beats a simultaneous CPU clear
        irq_set = raise_irq & ~raise_irq_q;
        irq_clr = wr && (ofs == IRQ_OFS) && p_wb_reg_SEL_I[0] && p_wb_reg_DAT_I[0];
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end

        rdata = 32'd0;
        case (ofs)
            ADDR_OFS: rdata = addr_q;
            IRQ_OFS: begin
                rdata[IRQ_BIT]  = irq_q;
                rdata[INIT_BIT] = init_q;
            end
            default: rdata = 32'd0;
        endcase
        dat_d = rd ? rdata : dat_q;
    end

    // State registers, all cleared by the async reset
    always_ff @(posedge p_clk_100mhz or negedge p_resetn) begin
        if (!p_resetn) begin
            addr_q      <= 32'd0;
            init_q      <= 1'b0;
            irq_q       <= 1'b0;
            raise_irq_q <= 1'b0;
            dat_q       <= 32'd0;
            ack_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            init_q      <= init_d;
            irq_q       <= irq_d;
            raise_irq_q <= raise_irq;
            dat_q       <= dat_d;
            ack_q       <= ack_d;
        end
    end

    assign module_register = addr_q;
    assign initialized     = init_q;
    assign irq             = irq_q;
    assign p_wb_reg_DAT_O  = dat_q;
    assign p_wb_reg_ACK_O  = ack_q;
    assign p_wb_reg_ERR_O  = 1'b0;
    assign p_wb_reg_RTY_O  = 1'b0;

endmodule

// File: tb/tb_wb_soc_reg_slave.sv
// Directed bench for wb_soc_reg_slave: vector table plus interrupt, ACK and reset sequences.
module tb_wb_soc_reg_slave;

    logic        clk;
    logic        rstn;
    logic        raise_irq;
    logic        irq;
    logic [31:0] module_register;
    logic        initialized;
    logic [31:0] dat_i, dat_o, adr;
    logic        ack, cyc, err, lock, rty, stb, we;
    logic [3:0]  sel;

    int errors = 0;
    int checks = 0;

    wb_soc_reg_slave dut (
        .p_clk_100mhz    (clk),
        .p_resetn        (rstn),
        .raise_irq       (raise_irq),
        .irq             (irq),
        .module_register (module_register),
        .initialized     (initialized),
        .p_wb_reg_DAT_I  (dat_i),
        .p_wb_reg_DAT_O  (dat_o),
        .p_wb_reg_ADR_I  (adr),
        .p_wb_reg_ACK_O  (ack),
        .p_wb_reg_CYC_I  (cyc),
        .p_wb_reg_ERR_O  (err),
        .p_wb_reg_LOCK_I (lock),
        .p_wb_reg_RTY_O  (rty),
        .p_wb_reg_SEL_I  (sel),
        .p_wb_reg_STB_I  (stb),
        .p_wb_reg_WE_I   (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [31:0] exp_mr;
        logic        exp_init;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One Wishbone transaction; returns the read data and the edges waited for ACK (0 = timeout)
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output int lat);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        lat = 0;
        rd  = 32'hx;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = n;
                rd  = dat_o;
                break;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;

    initial begin
        rstn = 1'b0; raise_irq = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; lock = 1'b0;
        adr = 32'd0; dat_i = 32'd0; sel = 4'd0;

        //           we    adr          dat          sel    exp_rd       exp_mr       init  irq
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'h4100_0000, 4'hF, 32'h0,         32'h4100_0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'h0000_0002, 32'h4100_0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'h4100_0000, 32'h4100_0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0000_00AB, 4'h1, 32'h0,         32'h4100_00AB, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0,         32'h4100_00AB, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'h6, 32'h0,         32'h4134_56AB, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0,         32'h4134_56AB, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0008, 32'h0,        4'hF, 32'h0000_0000, 32'h4134_56AB, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_000C, 32'h0,        4'hF, 32'h0000_0000, 32'h4134_56AB, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'h4134_56AB, 32'h4134_56AB, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0004, 32'h0000_0000, 4'hF, 32'h0,         32'h4134_56AB, 1'b1, 1'b0};

        #23;
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_dat", dat_o, 32'd0);
        chk("reset_mr", module_register, 32'd0);
        chk("reset_init", {31'd0, initialized}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); rstn = 1'b1;
        chk("err_tied", {31'd0, err}, 32'd0);
        chk("rty_tied", {31'd0, rty}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, lat);
            chk($sformatf("v%0d_latency", i), lat, 1);
            if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_mr", i), module_register, vecs[i].exp_mr);
            chk($sformatf("v%0d_init", i), {31'd0, initialized}, {31'd0, vecs[i].exp_init});
            chk($sformatf("v%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // STB without CYC, then CYC without STB: no ACK, no write
        @(negedge clk);
        cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_i = 32'hFFFF_FFFF; sel = 4'hF;
        @(posedge clk); #1;
        chk("nocyc_ack", {31'd0, ack}, 32'd0);
        @(negedge clk); cyc = 1'b1; stb = 1'b0;
        @(posedge clk); #1;
        chk("nostb_ack", {31'd0, ack}, 32'd0);
        @(negedge clk); cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        chk("noack_ack", {31'd0, ack}, 32'd0);
        chk("nocyc_mr", module_register, 32'h4134_56AB);

        // Interrupt: edge sets, level hold and fall keep it, CPU clear
        @(negedge clk); raise_irq = 1'b1;
        @(posedge clk); #1;
        chk("irq_set_latency", {31'd0, irq}, 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk); raise_irq = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("irq_held_after_fall", {31'd0, irq}, 32'd1);
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        chk("irq_reg_read", rd, 32'h0000_0003);
        wb_xfer(1'b1, 32'h4, 32'h1, 4'h2, rd, lat);
        chk("irq_clr_sel0_off", {31'd0, irq}, 32'd1);
        wb_xfer(1'b1, 32'h4, 32'h0, 4'h1, rd, lat);
        chk("irq_write_zero", {31'd0, irq}, 32'd1);
        wb_xfer(1'b1, 32'h4, 32'h1, 4'h1, rd, lat);
        chk("irq_clear", {31'd0, irq}, 32'd0);
        @(negedge clk); raise_irq = 1'b1;
        @(posedge clk); #1;
        chk("irq_reedge", {31'd0, irq}, 32'd1);
        @(negedge clk); raise_irq = 1'b0;
        wb_xfer(1'b1, 32'h4, 32'h1, 4'h1, rd, lat);
        chk("irq_clear2", {31'd0, irq}, 32'd0);

        // Rising edge and clear write accepted at the same edge: set wins
        @(negedge clk);
        raise_irq = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; dat_i = 32'h1; sel = 4'h1;
        @(posedge clk); #1;
        chk("setwins_ack", {31'd0, ack}, 32'd1);
        chk("setwins_irq", {31'd0, irq}, 32'd1);
        @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb_xfer(1'b1, 32'h4, 32'h1, 4'h1, rd, lat);
        chk("clear_while_level_high", {31'd0, irq}, 32'd0);
        @(negedge clk); raise_irq = 1'b0;

        // Held read: ACK 0,1,0,1,0,1
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        #1 chk("held_ack_0", {31'd0, ack}, 32'd0);
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held_ack_%0d", k), {31'd0, ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk); cyc = 1'b0; stb = 1'b0;

        // Async reset in the middle of an acknowledged cycle
        @(negedge clk); raise_irq = 1'b1;
        @(negedge clk); raise_irq = 1'b0;
        chk("pre_reset_irq", {31'd0, irq}, 32'd1);
        @(negedge clk); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        @(posedge clk); #1;
        chk("pre_reset_ack", {31'd0, ack}, 32'd1);
        chk("pre_reset_dat", dat_o, 32'h4134_56AB);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_dat", dat_o, 32'd0);
        chk("midrst_mr", module_register, 32'd0);
        chk("midrst_init", {31'd0, initialized}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); rstn = 1'b1; cyc = 1'b0; stb = 1'b0;
        wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
        chk("post_reset_latency", lat, 1);
        chk("post_reset_irqreg", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
